// File: rtl/alu_pkg.sv
// Shared types for the sequential ALU: opcodes, FSM states and the status flag bundle.
package alu_pkg;

  localparam int unsigned OP_W = 4;

  typedef enum logic [OP_W-1:0] {
    OP_ADD  = 4'd0,
    OP_INC  = 4'd1,
    OP_SUB  = 4'd2,
    OP_DEC  = 4'd3,
    OP_AND  = 4'd4,
    OP_NAND = 4'd5,
    OP_OR   = 4'd6,
    OP_XOR  = 4'd7,
    OP_SHL  = 4'd8,
    OP_SHR  = 4'd9,
    OP_MUL  = 4'd10
  } op_e;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_MUL_BUSY = 2'd1,
    ST_DONE     = 2'd2
  } state_e;

  typedef struct packed {
    logic c;
    logic z;
    logic n;
    logic v;
    logic err;
  } flags_t;

endpackage

// File: rtl/alu_mul_seq.sv
// Unsigned shift-add multiplier: one partial-product step per clock, WIDTH steps per product.
module alu_mul_seq #(
  parameter int unsigned WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start_i,
  input  logic [WIDTH-1:0]     a_i,
  input  logic [WIDTH-1:0]     b_i,
  output logic                 done_c,
  output logic [2*WIDTH-1:0]   product_c
);

  localparam int unsigned PW    = 2 * WIDTH;
  localparam int unsigned CNT_W = $clog2(WIDTH);

  logic [PW-1:0]    mcand_q, mcand_d;
  logic [PW-1:0]    acc_q, acc_d;
  logic [WIDTH-1:0] mplier_q, mplier_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             busy_q, busy_d;
  logic [PW-1:0]    step_acc;

  // The final step's sum is exposed combinationally so the caller captures it on the WIDTH-th edge.
  always_comb begin
    step_acc  = acc_q + (mplier_q[0] ? mcand_q : '0);
    done_c    = busy_q && (cnt_q == CNT_W'(WIDTH - 1));
    product_c = step_acc;
  end

  always_comb begin
    mcand_d  = mcand_q;
    acc_d    = acc_q;
    mplier_d = mplier_q;
    cnt_d    = cnt_q;
    busy_d   = busy_q;
    if (start_i) begin
      mcand_d  = {{WIDTH{1'b0}}, a_i};
      mplier_d = b_i;
      acc_d    = '0;
      cnt_d    = '0;
      busy_d   = 1'b1;
    end else if (busy_q) begin
      acc_d    = step_acc;
      mcand_d  = {mcand_q[PW-2:0], 1'b0};
      mplier_d = {1'b0, mplier_q[WIDTH-1:1]};
      cnt_d    = cnt_q + CNT_W'(1);
      busy_d   = !done_c;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      mcand_q  <= '0;
      acc_q    <= '0;
      mplier_q <= '0;
      cnt_q    <= '0;
      busy_q   <= 1'b0;
    end else begin
      mcand_q  <= mcand_d;
      acc_q    <= acc_d;
      mplier_q <= mplier_d;
      cnt_q    <= cnt_d;
      busy_q   <= busy_d;
    end
  end

endmodule

// File: rtl/alu_seq.sv
// Handshaked ALU: single-cycle ops plus a sequential multiply, registered result and flags.
module alu_seq
  import alu_pkg::*;
#(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [OP_W-1:0]  op,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] res,
  output logic [WIDTH-1:0] res_hi,
  output logic             flag_c,
  output logic             flag_z,
  output logic             flag_n,
  output logic             flag_v,
  output logic             flag_err
);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic [WIDTH-1:0] res_hi_q, res_hi_d;
  flags_t           flags_q, flags_d;

  op_e              op_sel;
  logic [WIDTH-1:0] rhs;
  logic [WIDTH:0]   add_w, sub_w;
  logic [WIDTH-1:0] alu_res;
  flags_t           alu_flags;

  logic               in_ready_c;
  logic               accept;
  logic               mul_start;
  logic               mul_done_c;
  logic [2*WIDTH-1:0] mul_prod_c;
  logic [WIDTH-1:0]   prod_hi, prod_lo;

  alu_mul_seq #(.WIDTH(WIDTH)) u_mul (
    .clk       (clk),
    .rst       (rst),
    .start_i   (mul_start),
    .a_i       (a),
    .b_i       (b),
    .done_c    (mul_done_c),
    .product_c (mul_prod_c)
  );

  assign prod_hi = mul_prod_c[2*WIDTH-1:WIDTH];
  assign prod_lo = mul_prod_c[WIDTH-1:0];

  // Single-cycle datapath; INC/DEC reuse the adder/subtractor with a constant 1 operand.
  always_comb begin
    op_sel    = op_e'(op);
    rhs       = ((op_sel == OP_INC) || (op_sel == OP_DEC)) ? WIDTH'(1) : b;
    add_w     = {1'b0, a} + {1'b0, rhs};
    sub_w     = {1'b0, a} - {1'b0, rhs};
    alu_res   = '0;
    alu_flags = '0;
    case (op_sel)
      OP_ADD, OP_INC: begin
        alu_res     = add_w[WIDTH-1:0];
        alu_flags.c = add_w[WIDTH];
        alu_flags.v = (a[WIDTH-1] == rhs[WIDTH-1]) && (add_w[WIDTH-1] != a[WIDTH-1]);
      end
      OP_SUB, OP_DEC: begin
        alu_res     = sub_w[WIDTH-1:0];
        alu_flags.c = sub_w[WIDTH];
        alu_flags.v = (a[WIDTH-1] != rhs[WIDTH-1]) && (sub_w[WIDTH-1] != a[WIDTH-1]);
      end
      OP_AND:  alu_res = a & b;
      OP_NAND: alu_res = ~(a & b);
      OP_OR:   alu_res = a | b;
      OP_XOR:  alu_res = a ^ b;
      OP_SHL: begin
        alu_res     = {a[WIDTH-2:0], 1'b0};
        alu_flags.c = a[WIDTH-1];
      end
      OP_SHR: begin
        alu_res     = {1'b0, a[WIDTH-1:1]};
        alu_flags.c = a[0];
      end
      default: alu_flags.err = 1'b1;
    endcase
    alu_flags.z = (alu_res == '0);
    alu_flags.n = alu_res[WIDTH-1];
  end

  // Next state and output-register loads; a new op may be accepted in IDLE or while DONE drains.
  always_comb begin
    state_d    = state_q;
    res_d      = res_q;
    res_hi_d   = res_hi_q;
    flags_d    = flags_q;
    mul_start  = 1'b0;
    in_ready_c = !rst && ((state_q == ST_IDLE) || ((state_q == ST_DONE) && out_ready));
    accept     = in_valid && in_ready_c;

    case (state_q)
      ST_MUL_BUSY: begin
        if (mul_done_c) begin
          res_d       = prod_lo;
          res_hi_d    = prod_hi;
          flags_d     = '0;
          flags_d.c   = (prod_hi != '0);
          flags_d.z   = (mul_prod_c == '0);
          flags_d.n   = prod_hi[WIDTH-1];
          state_d     = ST_DONE;
        end
      end
      ST_DONE: begin
        if (out_ready) state_d = ST_IDLE;
      end
      default: ;
    endcase

    if (accept) begin
      if (op_sel == OP_MUL) begin
        mul_start = 1'b1;
        state_d   = ST_MUL_BUSY;
      end else begin
        res_d    = alu_res;
        res_hi_d = '0;
        flags_d  = alu_flags;
        state_d  = ST_DONE;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      res_q    <= '0;
      res_hi_q <= '0;
      flags_q  <= '0;
    end else begin
      state_q  <= state_d;
      res_q    <= res_d;
      res_hi_q <= res_hi_d;
      flags_q  <= flags_d;
    end
  end

  assign in_ready  = in_ready_c;
  assign out_valid = (state_q == ST_DONE);
  assign res       = res_q;
  assign res_hi    = res_hi_q;
  assign flag_c    = flags_q.c;
  assign flag_z    = flags_q.z;
  assign flag_n    = flags_q.n;
  assign flag_v    = flags_q.v;
  assign flag_err  = flags_q.err;

endmodule

// File: doc/alu_seq.md
# alu_seq

Parametrised, handshaked ALU: accepts one operation per transaction on a valid/ready input, returns a registered result plus status flags on a valid/ready output. Single-cycle ops complete in one clock; multiply runs on an internal shift-add engine over WIDTH cycles. It is the datapath execution unit between an operand/opcode source and a result consumer.

## Interface
- WIDTH, 8: operand and result width (≥2)
- clk  in  1  clock; all state updates on rising edge
- rst  in  1  reset, synchronous, active-high
- in_valid  in  1  operand/opcode offered
- in_ready  out  1  block can accept this cycle
- a, b  in  WIDTH  operands (unsigned for carry, two's complement for ovf/neg)
- op  in  4  opcode (see Operation)
- out_valid  out  1  result/flags held valid
- out_ready  in  1  consumer takes result
- res  out  WIDTH  result, low half for MUL
- res_hi  out  WIDTH  MUL high half; 0 for all other ops
- flag_c, flag_z, flag_n, flag_v, flag_err  out  1 each  carry/borrow, zero, negative, signed overflow, illegal opcode

## Operation
- Opcodes: 0 ADD a+b; 1 INC a+1; 2 SUB a-b; 3 DEC a-1; 4 AND; 5 NAND; 6 OR; 7 XOR; 8 SHL a<<1; 9 SHR a>>1 (logical); 10 MUL a*b unsigned; 11-15 illegal.
- Width rule: all arithmetic computed at WIDTH+1 bits; res = low WIDTH bits.
- flag_c: ADD/INC carry-out; SUB/DEC borrow (1 when minuend < subtrahend); SHL a[WIDTH-1]; SHR a[0]; MUL 1 iff res_hi≠0; logic ops 0.
- flag_v: signed overflow for ADD/INC/SUB/DEC only, else 0.
- flag_z: res==0 (MUL: full 2·WIDTH product ==0). flag_n: res[WIDTH-1] (MUL: res_hi[WIDTH-1]).
- Illegal op: res=0, res_hi=0, flag_err=1, flag_z=1, others 0; completes as single-cycle op.
- FSM states: IDLE, MUL_BUSY, DONE.
  - IDLE: in_ready=1. Accept (in_valid&in_ready) of non-MUL → compute, register, go DONE. Accept of MUL → load multiplier, go MUL_BUSY.
  - MUL_BUSY: in_ready=0; one shift-add step per cycle; after WIDTH steps register product, go DONE.
  - DONE: out_valid=1; outputs stable until out_ready. out_ready=1: in_ready=1 same cycle; if in_valid also high, new op accepted (→DONE or MUL_BUSY), else → IDLE.
- Operands/op sampled only at accept; changes afterwards ignored.

## Timing
- Reset: state IDLE, out_valid=0, res=0, res_hi=0, all flags 0; in_ready=0 while rst high, 1 the cycle after.
- Non-MUL latency: accept at edge N → out_valid high after edge N.
- MUL latency: accept at edge N → out_valid high after edge N+WIDTH.
- Throughput: one non-MUL result per cycle when out_ready held high.
- Back-pressure: out_ready low holds res/flags/out_valid unchanged indefinitely; in_ready=0.
- rst mid-MUL or in DONE: transaction dropped, no out_valid pulse, reset values next cycle.
- in_valid in MUL_BUSY: not accepted; source must hold.

## Structure
- Package alu_pkg: opcode enum (OP_ADD..OP_MUL), FSM state enum, packed flag struct {c,z,n,v,err}.
- Sub-module alu_mul_seq: WIDTH-parameterised shift-add multiplier with start/done, 2·WIDTH product; top instantiates it and holds the combinational single-cycle ALU, FSM and output register.

## Test plan
- Reset then ADD a=8'hFF b=8'h01, out_ready=1 → next cycle res=00, c=1, z=1, v=0, n=0.
- SUB a=8'h80 b=8'h01 → res=7F, c=0, v=1, n=0; DEC a=00 → res=FF, c=1, n=1.
- MUL a=8'hFF b=8'hFF → in_ready low 8 cycles, out_valid 8 cycles after accept, res_hi=FE, res=01, c=1.
- Back-to-back stream XOR, SHL a=81, SHR a=01 with out_ready=1 → one result per cycle; SHL res=02 c=1; SHR res=00 c=1 z=1.
- out_ready low 5 cycles after OR result → res/flags stable, in_ready=0; op=4'hC → err=1, res=0.
- rst asserted 3 cycles into MUL → no out_valid, all outputs 0, in_ready=1 after release.
